// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with TX FIFO and status word (optional parity: UART_TX_PARITY_EN)
module uart_tx_fifo #(
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              clr_ovf,
  output logic [31:0]       status,
  output logic              tx_busy,
  output logic              uart_txd
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       level;
  logic              full, empty, push, pop, ovf;
  logic [DATA_W-1:0] head;
  logic [7:0]        level8;

  state_t            state, state_n;
  logic [BW-1:0]     baud_cnt, baud_n;
  logic [2:0]        bit_idx, bit_n;
  logic [DATA_W-1:0] data_r, data_n;
  logic              txd_n, bit_done;

  assign full     = (level == (AW+1)'(FIFO_DEPTH));
  assign empty    = (level == '0);
  assign wr_ready = !full;
  assign push     = wr_valid && !full;
  assign head     = mem[rd_ptr];
  assign tx_busy  = (state != S_IDLE);
  assign bit_done = (baud_cnt == BW'(CLKS_PER_BIT - 1));

  // FIFO storage; contents need no reset since level gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers and level; a full FIFO never accepts, even alongside a pop
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Sticky overflow; a dropped push in the same cycle as a clear keeps it set
  always_ff @(posedge clk) begin
    if (reset)                  ovf <= 1'b0;
    else if (wr_valid && full)  ovf <= 1'b1;
    else if (clr_ovf)           ovf <= 1'b0;
  end

  // Transmitter state register; the serial line is driven straight from a flop
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      data_r   <= '0;
      uart_txd <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      data_r   <= data_n;
      uart_txd <= txd_n;
    end
  end

  // Next-state logic; every bit boundary restarts the baud counter
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt + 1'b1;
    bit_n   = bit_idx;
    data_n  = data_r;
    txd_n   = uart_txd;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        baud_n = '0;
        txd_n  = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          data_n  = head;
          state_n = S_START;
          txd_n   = 1'b0;
        end
      end
      S_START: begin
        if (bit_done) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = S_DATA;
          txd_n   = data_r[0];
        end
      end
      S_DATA: begin
        if (bit_done) begin
          baud_n = '0;
          if (bit_idx == 3'(DATA_W - 1)) begin
            bit_n = '0;
`ifdef UART_TX_PARITY_EN
            state_n = S_PARITY;
            txd_n   = ^data_r;
`else
            state_n = S_STOP;
            txd_n   = 1'b1;
`endif
          end else begin
            bit_n = bit_idx + 1'b1;
            txd_n = data_r[bit_n];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = S_STOP;
          txd_n   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_done) begin
          baud_n = '0;
          if (bit_idx == 3'(STOP_BITS - 1)) begin
            bit_n = '0;
            if (!empty) begin
              pop     = 1'b1;
              data_n  = head;
              state_n = S_START;
              txd_n   = 1'b0;
            end else begin
              state_n = S_IDLE;
              txd_n   = 1'b1;
            end
          end else begin
            bit_n = bit_idx + 1'b1;
            txd_n = 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        txd_n   = 1'b1;
      end
    endcase
  end

  // Status word assembled from current registered state
  always_comb begin
    level8          = '0;
    level8[AW:0]    = level;
    status          = '0;
    status[0]       = !full;
    status[1]       = empty;
    status[2]       = tx_busy;
    status[3]       = ovf;
    status[15:8]    = level8;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized self-checking bench for uart_tx_fifo against a line-level model
module tb_uart_tx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CPB   = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P  = 1;
  localparam int SB = 2;
`else
  localparam int P  = 0;
  localparam int SB = 1;
`endif
  localparam int FL = (1 + DW + P + SB) * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        clr_ovf = 1'b0;
  logic        wr_ready;
  logic [31:0] status;
  logic        tx_busy;
  logic        uart_txd;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DATA_W(DW), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .STOP_BITS(SB)
  ) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .clr_ovf(clr_ovf), .status(status),
    .tx_busy(tx_busy), .uart_txd(uart_txd)
  );

  int n_checks = 0;
  int n_err    = 0;

  // model: queued bytes, per-cycle line levels of the frame in flight, sticky overflow
  logic [7:0] m_fifo [$];
  logic       m_wave [$];
  logic       m_ovf = 1'b0;

  int busy_cnt;
  int low_cnt;
  int pct;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the model, using the state held before that edge
  task automatic model_edge(input logic v, input logic [7:0] d, input logic c, input logic r);
    bit         pre_full;
    logic [7:0] b;
    logic       lv;
    if (r) begin
      m_fifo.delete();
      m_wave.delete();
      m_ovf = 1'b0;
      return;
    end
    pre_full = (m_fifo.size() == DEPTH);
    if (m_wave.size() <= 1 && m_fifo.size() != 0) begin
      b = m_fifo.pop_front();
      m_wave.delete();
      for (int k = 0; k < 1 + DW + P + SB; k++) begin
        if (k == 0)                  lv = 1'b0;
        else if (k <= DW)            lv = b[k-1];
        else if (P == 1 && k == DW+1) lv = ^b;
        else                         lv = 1'b1;
        repeat (CPB) m_wave.push_back(lv);
      end
    end else if (m_wave.size() != 0) begin
      void'(m_wave.pop_front());
    end
    if (v && !pre_full) m_fifo.push_back(d);
    if (v && pre_full)  m_ovf = 1'b1;
    else if (c)         m_ovf = 1'b0;
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic c, input logic r);
    logic [31:0] es;
    wr_valid = v;
    wr_data  = d;
    clr_ovf  = c;
    reset    = r;
    @(posedge clk);
    model_edge(v, d, c, r);
    #1;
    es        = '0;
    es[0]     = (m_fifo.size() != DEPTH);
    es[1]     = (m_fifo.size() == 0);
    es[2]     = (m_wave.size() != 0);
    es[3]     = m_ovf;
    es[15:8]  = 8'(m_fifo.size());
    check("txd",      32'(uart_txd), 32'(m_wave.size() != 0 ? m_wave[0] : 1'b1));
    check("busy",     32'(tx_busy),  32'(m_wave.size() != 0));
    check("wr_ready", 32'(wr_ready), 32'(m_fifo.size() != DEPTH));
    check("status",   status, es);
  endtask

  initial begin
    // reset held three cycles
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1);
    check("rst_status",   status, 32'h0000_0003);
    check("rst_txd",      32'(uart_txd), 32'd1);
    check("rst_busy",     32'(tx_busy), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // single frame of 0x55
    step(1'b1, 8'h55, 1'b0, 1'b0);
    check("start_not_yet", 32'(uart_txd), 32'd1);
    busy_cnt = 0;
    for (int i = 0; i < FL + 10; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      if (i == 0) check("start_low", 32'(uart_txd), 32'd0);
      busy_cnt += int'(tx_busy);
    end
    check("frame_busy_cycles", 32'(busy_cnt), 32'(FL));
    check("idle_status", status, 32'h0000_0003);

    // burst of 18 pushes: 17 accepted, last dropped, frames back-to-back
    busy_cnt = 0;
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 8'($urandom), 1'b0, 1'b0);
      busy_cnt += int'(tx_busy);
      if (i == 16) check("full_wr_ready", 32'(wr_ready), 32'd0);
    end
    check("burst_level", 32'(status[15:8]), 32'd16);
    check("burst_ovf",   32'(status[3]), 32'd1);

    // overflow clear, then drop and clear together
    step(1'b0, 8'h00, 1'b1, 1'b0);
    busy_cnt += int'(tx_busy);
    check("ovf_cleared", 32'(status[3]), 32'd0);
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    busy_cnt += int'(tx_busy);
    check("ovf_set_wins", 32'(status[3]), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    busy_cnt += int'(tx_busy);
    for (int i = 0; i < 17 * FL; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      busy_cnt += int'(tx_busy);
    end
    check("back_to_back_busy", 32'(busy_cnt), 32'(17 * FL));
    check("drained_status", status, 32'h0000_0003);

    // reset during data bit 3 of 0xA3 with two bytes queued
    step(1'b1, 8'hA3, 1'b0, 1'b0);
    step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'($urandom), 1'b0, 1'b0);
    repeat (16) step(1'b0, 8'h00, 1'b0, 1'b0);
    check("pre_rst_level", 32'(status[15:8]), 32'd2);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("midrst_txd",    32'(uart_txd), 32'd1);
    check("midrst_status", status, 32'h0000_0003);
    low_cnt = 0;
    for (int i = 0; i < 3 * FL; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      low_cnt += int'(!uart_txd);
    end
    check("no_start_after_rst", 32'(low_cnt), 32'd0);

    // 0x07: parity bit (when built in) sits right after the eight data bits
    step(1'b1, 8'h07, 1'b0, 1'b0);
    for (int i = 0; i < FL + 5; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
`ifdef UART_TX_PARITY_EN
      if (i == 36) check("parity_bit", 32'(uart_txd), 32'd1);
`endif
    end

    // randomized traffic with varying push density, clears and rare resets
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) pct = int'($urandom_range(1, 60));
      step(($urandom_range(0, 99) < pct), 8'($urandom),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 1499) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
